rs_divider_scheduler: RTL and testbench
=======================================

Name: rs_divider_scheduler

Overview:
- Shares one pipelined 15/10-bit unsigned divider among NUM_REQ requesters, one per RS decoder channel, using round-robin arbitration.
- Issues at most one division per cycle and tracks each in-flight operation with a tag shift register.
- Returns each result, one-hot tagged, to the requester that issued it.
- Detects zero denominators and forces a defined result for them.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DIV_LATENCY, 4, divider cycles from registered operands to valid quotient/remain (>=1)
NUMER_W, 15, numerator/quotient width
DENOM_W, 10, denominator/remainder width

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_numer  in  NUM_REQ*NUMER_W  packed numerators; requester i at [i*NUMER_W +: NUMER_W]
req_denom  in  NUM_REQ*DENOM_W  packed denominators; same packing
req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i]
div_numer  out  NUMER_W  registered operand to divider
div_denom  out  DENOM_W  registered operand to divider
div_quotient  in  NUMER_W  divider quotient
div_remain  in  DENOM_W  divider remainder
rsp_valid  out  NUM_REQ  one-hot, single-cycle result strobe to owning requester
rsp_quotient  out  NUMER_W  result quotient
rsp_remain  out  DENOM_W  result remainder
rsp_dz  out  1  result came from a zero denominator
busy  out  1  any operation registered or in flight

Behaviour:
- Reset (resetn=0 at a clock edge):
  - rr pointer = NUM_REQ-1, so requester 0 has first priority.
  - Operand registers = 0; tag pipeline cleared.
  - rsp_valid = 0, rsp_quotient = 0, rsp_remain = 0, rsp_dz = 0, busy = 0.
  - req_ready = 0 while resetn is low.
- Arbitration:
  - req_ready is combinational from req_valid and the rr pointer.
  - Search starts at pointer+1 mod NUM_REQ; the first requester with req_valid set is granted.
  - At most one grant bit is set; all zero if no request.
  - On a transfer, the pointer updates to the granted index. With no transfer, the pointer holds.
- Requester rules: req_numer/req_denom must stay stable while req_valid=1 and not granted. A requester may deassert req_valid without a grant; the scheduler takes no action.
- Issue, at the transfer edge:
  - div_numer/div_denom are loaded from the granted requester.
  - A tag {valid=1, one-hot owner, dz=(denom==0)} enters stage 0 of a DIV_LATENCY+1 deep shift register.
  - With no transfer, a tag with valid=0 enters; operand registers hold their values.
- Throughput: one issue per cycle with no bubbles. There is no backpressure on results; requesters must accept rsp_valid in any cycle.
- Latency: transfer at edge T → rsp_valid high for exactly the cycle after edge T+DIV_LATENCY+1. Example: ready/valid seen in cycle 0 → rsp_valid in cycle DIV_LATENCY+1.
- Response register, updated every edge from the last tag stage and the divider outputs:
  - rsp_valid = owner bits when tag valid, else 0.
  - Normal case: rsp_quotient = div_quotient, rsp_remain = div_remain, rsp_dz = 0.
  - dz case: rsp_quotient = all ones (0x7FFF), rsp_remain = 0, rsp_dz = 1. Divider output is ignored.
  - When no tag is valid, data outputs hold their previous values.
- busy = OR of all tag-stage valid bits and the rsp_valid register.
- A requester may have several operations outstanding. Results return in issue order.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid occurs for operations issued before reset. The pointer returns to its reset value.
- Simultaneous events: a new issue and a result delivery in the same cycle are independent.
- Widths: arithmetic is unsigned. No width extension is applied; ports match the divider exactly.

Test Plan:
- Single request: req 1 requests 1000/7 → req_ready[1] same cycle; DIV_LATENCY+1 cycles later rsp_valid=3'b010, quotient=142, remain=6, dz=0 for one cycle.
- Contention: all three valid from cycle 0, held until granted → grants 0, 1, 2 in cycles 0, 1, 2. Responses with 32767/1023 (q=32, r=31) arrive on three consecutive cycles, owners 001, 010, 100.
- Fairness/throughput: req 0 and req 2 continuously valid for 10 cycles → grants alternate 0, 2, 0, 2. One issue every cycle, no idle cycles. Pointer correctly skips idle req 1.
- Divide by zero: req 2 requests 255/0 → rsp_valid=100, quotient=0x7FFF, remain=0, dz=1. The next operation, 20/3, returns q=6, r=2, dz=0.
- Reset mid-flight: issue 3 operations, assert resetn=0 for 1 cycle at cycle 2 → no rsp_valid afterwards, busy=0. Next request is granted to requester 0 first.
- Withdrawn request: req 1 valid for one cycle while req 0 is granted, then drops → no grant to 1, no response for 1, pointer=0.

Source files
------------

// File: rtl/rs_divider_scheduler.sv
// Round-robin scheduler sharing one pipelined divider among RS decoder channels.
// Tags follow each operation through the divider and steer the result back.
module rs_divider_scheduler #(
    parameter int NUM_REQ     = 3,
    parameter int DIV_LATENCY = 4,
    parameter int NUMER_W     = 15,
    parameter int DENOM_W     = 10
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*NUMER_W-1:0]   req_numer,
    input  logic [NUM_REQ*DENOM_W-1:0]   req_denom,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUMER_W-1:0]           div_numer,
    output logic [DENOM_W-1:0]           div_denom,
    input  logic [NUMER_W-1:0]           div_quotient,
    input  logic [DENOM_W-1:0]           div_remain,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [NUMER_W-1:0]           rsp_quotient,
    output logic [DENOM_W-1:0]           rsp_remain,
    output logic                         rsp_dz,
    output logic                         busy
);

    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = DIV_LATENCY + 1;

    typedef struct packed {
        logic               vld;
        logic [NUM_REQ-1:0] own;
        logic               dz;
    } tag_t;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    int                 idx;
    logic               xfer;
    logic [NUMER_W-1:0] sel_numer;
    logic [DENOM_W-1:0] sel_denom;
    tag_t               tags [DEPTH];
    tag_t               last;

    // Search begins just past the last winner so every channel gets a turn.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
        if (!resetn) begin
            grant = '0;
        end
    end

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);
    assign sel_numer = req_numer[int'(gidx)*NUMER_W +: NUMER_W];
    assign sel_denom = req_denom[int'(gidx)*DENOM_W +: DENOM_W];
    assign last      = tags[DEPTH-1];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ptr          <= PW'(NUM_REQ - 1);
            div_numer    <= '0;
            div_denom    <= '0;
            rsp_valid    <= '0;
            rsp_quotient <= '0;
            rsp_remain   <= '0;
            rsp_dz       <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                tags[k] <= '0;
            end
        end else begin
            if (xfer) begin
                ptr       <= gidx;
                div_numer <= sel_numer;
                div_denom <= sel_denom;
                tags[0]   <= '{vld: 1'b1, own: grant, dz: (sel_denom == '0)};
            end else begin
                tags[0] <= '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                tags[k] <= tags[k-1];
            end
            // A zero denominator overrides whatever the divider produced.
            if (last.vld) begin
                rsp_valid <= last.own;
                if (last.dz) begin
                    rsp_quotient <= '1;
                    rsp_remain   <= '0;
                    rsp_dz       <= 1'b1;
                end else begin
                    rsp_quotient <= div_quotient;
                    rsp_remain   <= div_remain;
                    rsp_dz       <= 1'b0;
                end
            end else begin
                rsp_valid <= '0;
            end
        end
    end

    always_comb begin
        busy = |rsp_valid;
        for (int k = 0; k < DEPTH; k++) begin
            busy = busy | tags[k].vld;
        end
    end

endmodule

// File: tb/tb_rs_divider_scheduler.sv
// Scoreboard bench for rs_divider_scheduler with a behavioural divider model.
// Directed stimulus pushes expected results; a negedge monitor pops and checks.
module tb_rs_divider_scheduler;

    localparam int N  = 3;
    localparam int L  = 4;
    localparam int NW = 15;
    localparam int DW = 10;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*NW-1:0] req_numer = '0;
    logic [N*DW-1:0] req_denom = '0;
    logic [N-1:0]    req_ready;
    logic [NW-1:0]   div_numer;
    logic [DW-1:0]   div_denom;
    logic [NW-1:0]   div_quotient;
    logic [DW-1:0]   div_remain;
    logic [N-1:0]    rsp_valid;
    logic [NW-1:0]   rsp_quotient;
    logic [DW-1:0]   rsp_remain;
    logic            rsp_dz;
    logic            busy;

    always #5 clock = ~clock;

    rs_divider_scheduler #(
        .NUM_REQ(N), .DIV_LATENCY(L), .NUMER_W(NW), .DENOM_W(DW)
    ) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_numer(req_numer), .req_denom(req_denom),
        .req_ready(req_ready),
        .div_numer(div_numer), .div_denom(div_denom),
        .div_quotient(div_quotient), .div_remain(div_remain),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
        .rsp_remain(rsp_remain), .rsp_dz(rsp_dz), .busy(busy)
    );

    // External divider: L register stages behind the operand registers.
    // Zero denominators yield junk that the scheduler must discard.
    logic [NW-1:0] pq [L];
    logic [DW-1:0] pr [L];
    always @(posedge clock) begin
        if (div_denom == '0) begin
            pq[0] <= 15'h1234;
            pr[0] <= 10'h2AA;
        end else begin
            pq[0] <= div_numer / NW'(div_denom);
            pr[0] <= DW'(div_numer % NW'(div_denom));
        end
        for (int k = 1; k < L; k++) begin
            pq[k] <= pq[k-1];
            pr[k] <= pr[k-1];
        end
    end
    assign div_quotient = pq[L-1];
    assign div_remain   = pr[L-1];

    typedef struct {
        logic [N-1:0]  own;
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        int            due;
    } exp_t;

    exp_t sbq [$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    logic [NW-1:0] rn [N];
    logic [DW-1:0] rd [N];
    logic [NW-1:0] eq [N];
    logic [DW-1:0] er [N];
    logic          edz [N];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: any strobe must match the oldest expectation, on its due cycle.
    always @(negedge clock) begin
        if (resetn) begin
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("rsp_owner", 32'(rsp_valid), 32'(mon_e.own));
                    check("rsp_quotient", 32'(rsp_quotient), 32'(mon_e.q));
                    check("rsp_remain", 32'(rsp_remain), 32'(mon_e.r));
                    check("rsp_dz", 32'(rsp_dz), 32'(mon_e.dz));
                    check("rsp_cycle", cyc, mon_e.due);
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                mon_e = sbq.pop_front();
                check("rsp_valid_at_due", 32'(rsp_valid), 32'(mon_e.own));
            end
        end
    end

    task automatic set_req(input int i, input logic [NW-1:0] n, input logic [DW-1:0] d,
                           input logic [NW-1:0] q, input logic [DW-1:0] r, input logic dz);
        rn[i]  = n;
        rd[i]  = d;
        eq[i]  = q;
        er[i]  = r;
        edz[i] = dz;
    endtask

    task automatic step(input logic [N-1:0] valid, input logic [N-1:0] exp_grant,
                        input string name);
        exp_t e;
        @(negedge clock);
        req_valid = valid;
        for (int i = 0; i < N; i++) begin
            req_numer[i*NW +: NW] = rn[i];
            req_denom[i*DW +: DW] = rd[i];
        end
        #1;
        check(name, 32'(req_ready), 32'(exp_grant));
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.own    = '0;
                e.own[i] = 1'b1;
                e.q      = eq[i];
                e.r      = er[i];
                e.dz     = edz[i];
                e.due    = cyc + L + 2;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() > 0 && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (sbq.size() > 0) begin
            check("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn    = 1'b0;
        req_valid = '1;
        #1;
        check("ready_in_reset", 32'(req_ready), 32'd0);
        sbq.delete();
        @(negedge clock);
        resetn    = 1'b1;
        req_valid = '0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_req(i, '0, '0, '0, '0, 1'b0);

        // Power-on reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        req_valid = '1;
        #1;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_quotient", 32'(rsp_quotient), 32'd0);
        check("reset_remain", 32'(rsp_remain), 32'd0);
        check("reset_dz", 32'(rsp_dz), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_div_numer", 32'(div_numer), 32'd0);
        check("reset_div_denom", 32'(div_denom), 32'd0);
        @(negedge clock);
        resetn    = 1'b1;
        req_valid = '0;

        // Single request: 1000/7 = 142 r 6
        set_req(1, 15'd1000, 10'd7, 15'd142, 10'd6, 1'b0);
        step(3'b010, 3'b010, "single_grant");
        step(3'b000, 3'b000, "single_idle");
        check("busy_inflight", 32'(busy), 32'd1);
        drain();
        check("busy_after_single", 32'(busy), 32'd0);

        // Contention from reset: 32767/1023 = 32 r 31
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 15'd32767, 10'd1023, 15'd32, 10'd31, 1'b0);
        step(3'b111, 3'b001, "cont_g0");
        step(3'b110, 3'b010, "cont_g1");
        step(3'b100, 3'b100, "cont_g2");
        step(3'b000, 3'b000, "cont_idle");
        drain();

        // Fairness: 0 and 2 always valid, 1 idle
        set_req(0, 15'd100, 10'd10, 15'd10, 10'd0, 1'b0);
        set_req(2, 15'd999, 10'd100, 15'd9, 10'd99, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(3'b101, (k % 2 == 0) ? 3'b001 : 3'b100, "fair_grant");
        end
        check("fair_busy", 32'(busy), 32'd1);
        step(3'b000, 3'b000, "fair_idle");
        drain();

        // Zero denominator, then a normal 20/3 = 6 r 2
        set_req(2, 15'd255, 10'd0, 15'h7FFF, 10'd0, 1'b1);
        step(3'b100, 3'b100, "dz_grant");
        set_req(2, 15'd20, 10'd3, 15'd6, 10'd2, 1'b0);
        step(3'b100, 3'b100, "dz_next_grant");
        step(3'b000, 3'b000, "dz_idle");
        drain();
        check("hold_quotient", 32'(rsp_quotient), 32'd6);
        check("hold_remain", 32'(rsp_remain), 32'd2);
        check("hold_dz", 32'(rsp_dz), 32'd0);
        check("hold_busy", 32'(busy), 32'd0);

        // Withdrawn request from 1 while 0 wins; pointer must end at 0
        set_req(0, 15'd50, 10'd5, 15'd10, 10'd0, 1'b0);
        set_req(1, 15'd77, 10'd7, 15'd11, 10'd0, 1'b0);
        step(3'b011, 3'b001, "wd_g0");
        step(3'b000, 3'b000, "wd_none");
        step(3'b011, 3'b010, "wd_ptr_at_0");
        step(3'b000, 3'b000, "wd_idle");
        drain();

        // Reset with three operations in flight: 300/7 = 42 r 6
        for (int i = 0; i < N; i++) set_req(i, 15'd300, 10'd7, 15'd42, 10'd6, 1'b0);
        step(3'b111, 3'b100, "mf_g2");
        step(3'b011, 3'b001, "mf_g0");
        step(3'b010, 3'b010, "mf_g1");
        do_reset();
        check("mf_busy_after_reset", 32'(busy), 32'd0);
        repeat (L + 4) @(negedge clock);
        check("mf_busy_quiet", 32'(busy), 32'd0);
        step(3'b111, 3'b001, "mf_first_after_reset");
        step(3'b000, 3'b000, "mf_idle");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
